// File: rtl/noc_axis_flit_packetizer.sv
// AXI4-Stream to NoC flit packetizer: header/body/tail flits with per-VC credit flow control.
// Optional statistics counters are compiled in with `define NOC_PACKETIZER_STATS_EN.
module noc_axis_flit_packetizer #(
  parameter int unsigned FLIT_WIDTH                = 64,
  parameter int unsigned FLIT_TYPE_WIDTH           = 2,
  parameter int unsigned BROADCAST_WIDTH           = 1,
  parameter int unsigned VIRTUAL_CHANNEL_ID_WIDTH  = 2,
  parameter int unsigned NUMBEROF_VIRTUAL_CHANNELS = 4,
  parameter int unsigned NUMBEROF_VIRTUAL_NETWORKS = 4,
  parameter int unsigned VIRTUAL_NETWORK_ID_WIDTH  = 2,
  parameter int unsigned TDEST_WIDTH               = 16,
  parameter int unsigned BUFFER_DEPTH              = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [FLIT_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tlast,
  input  logic [TDEST_WIDTH-1:0]               s_axis_tdest,
  input  logic [VIRTUAL_NETWORK_ID_WIDTH-1:0]  s_axis_tid,
  input  logic [BROADCAST_WIDTH-1:0]           s_axis_tuser,
  output logic [FLIT_WIDTH-1:0]                flit_o,
  output logic [FLIT_TYPE_WIDTH-1:0]           flit_type_o,
  output logic [BROADCAST_WIDTH-1:0]           broadcast_o,
  output logic [VIRTUAL_CHANNEL_ID_WIDTH-1:0]  vc_id_o,
  output logic                                 flit_valid_o,
  input  logic [NUMBEROF_VIRTUAL_CHANNELS-1:0] credit_i,
  output logic                                 credit_overflow_o
`ifdef NOC_PACKETIZER_STATS_EN
  ,
  output logic [31:0]                          stat_packets_o,
  output logic [31:0]                          stat_flits_o
`endif
);

  localparam int unsigned CreditWidth = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned VcWidth     = VIRTUAL_CHANNEL_ID_WIDTH;
  localparam logic [CreditWidth-1:0]     CreditMax = CreditWidth'(BUFFER_DEPTH);
  localparam logic [FLIT_TYPE_WIDTH-1:0] TypeHead  = FLIT_TYPE_WIDTH'(0);
  localparam logic [FLIT_TYPE_WIDTH-1:0] TypeBody  = FLIT_TYPE_WIDTH'(1);
  localparam logic [FLIT_TYPE_WIDTH-1:0] TypeTail  = FLIT_TYPE_WIDTH'(2);

  typedef enum logic [0:0] {StIdle, StBody} state_e;

  function automatic logic [VcWidth-1:0] vc_of(input logic [VIRTUAL_NETWORK_ID_WIDTH-1:0] vn);
    return VcWidth'(32'(vn) % NUMBEROF_VIRTUAL_CHANNELS);
  endfunction

  state_e                       state_q;
  logic [FLIT_WIDTH-1:0]        flit_q;
  logic [FLIT_TYPE_WIDTH-1:0]   type_q;
  logic [BROADCAST_WIDTH-1:0]   bcast_q;
  logic [VcWidth-1:0]           vc_q;
  logic                         valid_q;
  logic [CreditWidth-1:0]       credit_q [NUMBEROF_VIRTUAL_CHANNELS];
  logic [CreditWidth-1:0]       credit_d [NUMBEROF_VIRTUAL_CHANNELS];
  logic                         overflow_q, overflow_d;

  logic [VcWidth-1:0]    tid_vc;
  logic [VcWidth-1:0]    emit_vc;
  logic                  hdr_go, beat_go, emit;
  logic [FLIT_WIDTH-1:0] header;

  assign tid_vc = vc_of(s_axis_tid);

  always_comb begin
    s_axis_tready = (state_q == StBody) && (credit_q[vc_q] != '0);
    hdr_go        = (state_q == StIdle) && s_axis_tvalid && (credit_q[tid_vc] != '0);
    beat_go       = s_axis_tvalid && s_axis_tready;
    emit          = hdr_go || beat_go;
    emit_vc       = hdr_go ? tid_vc : vc_q;
    header        = '0;
    header[TDEST_WIDTH-1:0]                          = s_axis_tdest;
    header[TDEST_WIDTH +: VIRTUAL_NETWORK_ID_WIDTH]  = s_axis_tid;
  end

  // The VC is latched with the header; mid-packet tid/tuser changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      flit_q  <= '0;
      type_q  <= '0;
      bcast_q <= '0;
      vc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (hdr_go) begin
            flit_q  <= header;
            type_q  <= TypeHead;
            vc_q    <= tid_vc;
            bcast_q <= s_axis_tuser;
            valid_q <= 1'b1;
            state_q <= StBody;
          end
        end
        StBody: begin
          if (beat_go) begin
            flit_q  <= s_axis_tdata;
            type_q  <= s_axis_tlast ? TypeTail : TypeBody;
            valid_q <= 1'b1;
            if (s_axis_tlast) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Emission and return in one cycle cancel; a return at full credit saturates and flags.
  always_comb begin
    overflow_d = overflow_q;
    for (int v = 0; v < int'(NUMBEROF_VIRTUAL_CHANNELS); v++) begin
      credit_d[v] = credit_q[v];
      if (credit_i[v] && !(emit && (emit_vc == VcWidth'(v)))) begin
        if (credit_q[v] == CreditMax) begin
          overflow_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + 1'b1;
        end
      end else if (!credit_i[v] && emit && (emit_vc == VcWidth'(v))) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < int'(NUMBEROF_VIRTUAL_CHANNELS); v++) begin
        credit_q[v] <= CreditMax;
      end
      overflow_q <= 1'b0;
    end else begin
      for (int v = 0; v < int'(NUMBEROF_VIRTUAL_CHANNELS); v++) begin
        credit_q[v] <= credit_d[v];
      end
      overflow_q <= overflow_d;
    end
  end

  assign flit_o            = flit_q;
  assign flit_type_o       = type_q;
  assign broadcast_o       = bcast_q;
  assign vc_id_o           = vc_q;
  assign flit_valid_o      = valid_q;
  assign credit_overflow_o = overflow_q;

`ifdef NOC_PACKETIZER_STATS_EN
  logic [31:0] stat_packets_q, stat_flits_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_packets_q <= '0;
      stat_flits_q   <= '0;
    end else if (valid_q) begin
      stat_flits_q <= stat_flits_q + 32'd1;
      if (type_q == TypeTail) begin
        stat_packets_q <= stat_packets_q + 32'd1;
      end
    end
  end

  assign stat_packets_o = stat_packets_q;
  assign stat_flits_o   = stat_flits_q;
`endif

endmodule
